// File: rtl/mosi_command_reader.sv
// mosi_command_reader: walks a RAM window (optionally looping) and hands out its words over a valid/ready handshake
module mosi_command_reader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk_B,
  input  logic              reset_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [ADDR_W-1:0] loop_addr,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] RAM_addr_B,
  input  logic [DATA_W-1:0] RAM_data_out_B,
  output logic [DATA_W-1:0] cmd_word,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              config_error,
  output logic [15:0]       pass_count
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_end, r_loop;
  logic r_loop_en, r_err, r_nw, r_dv, r_dv_end;
  logic [1:0] r_cnt;
  logic [DATA_W:0] r_q0, r_q1;
  logic [15:0] r_pass;
  logic w_bad, w_act, w_last, w_pop, w_push, w_dv_n, w_adv;
  logic [1:0] w_n, w_cnt_n;
  always_comb begin
    w_bad = (start_addr > end_addr) | (loop_en & ((loop_addr < start_addr) | (loop_addr > end_addr)));
    w_act = run & ((r_state == FETCH) | (r_state == DRAIN));
    w_last = (r_addr == r_end) & ~r_loop_en;
    w_pop = (r_cnt != 2'd0) & cmd_ready;
    w_n = r_cnt - {1'b0, w_pop};
    w_push = r_dv & (w_n != 2'd2);
    w_cnt_n = w_n + {1'b0, w_push};
    w_dv_n = r_nw | (r_dv & ~w_push);
    w_adv = w_act & (r_state == FETCH) & ~w_last & (({1'b0, w_cnt_n} + {2'b0, w_dv_n}) <= 3'd2);
    w_next = (r_state == IDLE) ? (run ? (w_bad ? DONE : FETCH) : IDLE) :
             !run ? IDLE :
             (r_state == FETCH) ? (w_last ? DRAIN : FETCH) :
             (r_state == DRAIN) ? ((r_cnt == 2'd0 && !r_dv && !r_nw) ? DONE : DRAIN) : DONE;
  end
  always_ff @(posedge clk_B) r_state <= !reset_n ? IDLE : w_next;
  always_ff @(posedge clk_B) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_end <= '0;
      r_loop <= '0;
      r_loop_en <= 1'b0;
      r_err <= 1'b0;
      r_nw <= 1'b0;
      r_dv <= 1'b0;
      r_dv_end <= 1'b0;
      r_cnt <= 2'd0;
      r_q0 <= '0;
      r_q1 <= '0;
      r_pass <= '0;
    end else if (r_state == IDLE && run) begin
      r_end <= end_addr;
      r_loop <= loop_addr;
      r_loop_en <= loop_en;
      r_err <= w_bad;
      if (!w_bad) begin
        r_addr <= start_addr;
        r_nw <= 1'b1;
        r_pass <= '0;
      end
    end else if (w_act) begin
      r_nw <= w_adv;
      r_dv <= w_dv_n;
      r_dv_end <= r_nw ? (r_addr == r_end) : r_dv_end;
      r_cnt <= w_cnt_n;
      if (w_adv) r_addr <= (r_addr == r_end) ? r_loop : r_addr + 1'b1;
      if (w_pop) r_q0 <= r_q1;
      if (w_push && w_n == 2'd0) r_q0 <= {r_dv_end, RAM_data_out_B};
      if (w_push && w_n == 2'd1) r_q1 <= {r_dv_end, RAM_data_out_B};
      if (w_pop && r_q0[DATA_W] && r_pass != 16'hFFFF) r_pass <= r_pass + 16'd1;
    end else begin
      r_nw <= 1'b0;
      r_dv <= 1'b0;
      r_cnt <= 2'd0;
    end
  end
  assign RAM_addr_B = r_addr;
  assign cmd_word = r_q0[DATA_W-1:0];
  assign cmd_valid = r_cnt != 2'd0;
  assign busy = (r_state == FETCH) | (r_state == DRAIN);
  assign done = r_state == DONE;
  assign config_error = done & r_err;
  assign pass_count = r_pass;
endmodule

// File: tb/tb_mosi_command_reader.sv
// tb_mosi_command_reader: directed bench for mosi_command_reader against a synchronous RAM model
module tb_mosi_command_reader;
  logic clk, reset_n, run, loop_en, cmd_ready, cmd_valid, busy, done, config_error;
  logic [12:0] start_addr, end_addr, loop_addr, RAM_addr_B;
  logic [15:0] ram_q, cmd_word, pass_count;
  logic [15:0] mem [8192];
  int total, bad;
  mosi_command_reader dut (
    .clk_B(clk), .reset_n(reset_n), .run(run), .start_addr(start_addr), .end_addr(end_addr),
    .loop_addr(loop_addr), .loop_en(loop_en), .RAM_addr_B(RAM_addr_B), .RAM_data_out_B(ram_q),
    .cmd_word(cmd_word), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .busy(busy), .done(done),
    .config_error(config_error), .pass_count(pass_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[RAM_addr_B];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 0;
    run = 0;
    cmd_ready = 0;
    tick();
    tick();
    total++; if (RAM_addr_B !== 13'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", RAM_addr_B); end
    total++; if (cmd_word !== 16'd0) begin bad++; $display("FAIL reset_word got=%h want=0", cmd_word); end
    total++; if ({cmd_valid, busy, done, config_error} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {cmd_valid, busy, done, config_error}); end
    total++; if (pass_count !== 16'd0) begin bad++; $display("FAIL reset_pass got=%0d want=0", pass_count); end
    reset_n = 1;
    tick();
  endtask
  task automatic test_single_pass();
    logic [15:0] ew [4] = '{16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3};
    int hs = 0;
    for (int i = 0; i < 4; i++) mem[100 + i] = ew[i];
    start_addr = 100;
    end_addr = 103;
    loop_addr = 0;
    loop_en = 0;
    cmd_ready = 1;
    run = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cmd_valid && cmd_ready) hs++;
      if (c == 0) begin
        total++; if (RAM_addr_B !== 13'd100) begin bad++; $display("FAIL single_first_addr got=%0d want=100", RAM_addr_B); end
      end
      total++; if (cmd_valid !== 1'(c >= 2 && c <= 5)) begin bad++; $display("FAIL single_valid c=%0d got=%b want=%b", c, cmd_valid, c >= 2 && c <= 5); end
      if (c >= 2 && c <= 5) begin
        total++; if (cmd_word !== ew[c-2]) begin bad++; $display("FAIL single_word c=%0d got=%h want=%h", c, cmd_word, ew[c-2]); end
      end
      total++; if (done !== 1'(c >= 7)) begin bad++; $display("FAIL single_done c=%0d got=%b want=%b", c, done, c >= 7); end
      total++; if (busy !== 1'(c <= 6)) begin bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, c <= 6); end
    end
    total++; if (hs !== 4) begin bad++; $display("FAIL single_handshakes got=%0d want=4", hs); end
    total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL single_pass got=%0d want=1", pass_count); end
    total++; if (config_error !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", config_error); end
    run = 0;
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_clear got=%b want=0", done); end
  endtask
  task automatic test_loop();
    int seq [9] = '{10, 11, 12, 11, 12, 11, 12, 11, 12};
    int k = 0, fc = 0, lc = 0;
    start_addr = 10;
    end_addr = 12;
    loop_addr = 11;
    loop_en = 1;
    cmd_ready = 1;
    run = 1;
    for (int c = 0; c < 40 && k < 9; c++) begin
      tick();
      if (cmd_valid) begin
        total++; if (cmd_word !== mem[seq[k]]) begin bad++; $display("FAIL loop_word k=%0d got=%h want=%h", k, cmd_word, mem[seq[k]]); end
        if (k == 0) fc = c;
        lc = c;
        k++;
      end
    end
    total++; if (k !== 9) begin bad++; $display("FAIL loop_count got=%0d want=9", k); end
    total++; if (lc - fc !== 8) begin bad++; $display("FAIL loop_throughput got=%0d want=8", lc - fc); end
    tick();
    cmd_ready = 0;
    total++; if (pass_count !== 16'd4) begin bad++; $display("FAIL loop_pass got=%0d want=4", pass_count); end
    tick();
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd_word !== mem[11]) begin bad++; $display("FAIL loop_stall_head got=%b/%h want=1/%h", cmd_valid, cmd_word, mem[11]); end
    run = 0;
    tick();
    total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL loop_abort got=%b%b want=00", cmd_valid, busy); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL loop_abort_done got=%b want=0", done); end
  endtask
  task automatic test_backpressure();
    int k = 0;
    logic pv = 0, pr = 0;
    logic [15:0] pw = 0;
    start_addr = 200;
    end_addr = 263;
    loop_en = 0;
    cmd_ready = 0;
    run = 1;
    for (int c = 0; c < 2000 && !done; c++) begin
      tick();
      if (pv && !pr) begin
        total++; if (cmd_valid !== 1'b1 || cmd_word !== pw) begin bad++; $display("FAIL bp_stable got=%b/%h want=1/%h", cmd_valid, cmd_word, pw); end
      end
      if (busy) begin
        total++; if (RAM_addr_B < 13'd200 || RAM_addr_B > 13'd263) begin bad++; $display("FAIL bp_addr got=%0d want=200..263", RAM_addr_B); end
      end
      cmd_ready = $urandom_range(0, 9) < 3;
      if (cmd_valid && cmd_ready) begin
        total++; if (cmd_word !== mem[200 + k]) begin bad++; $display("FAIL bp_word k=%0d got=%h want=%h", k, cmd_word, mem[200 + k]); end
        k++;
      end
      pv = cmd_valid;
      pr = cmd_ready;
      pw = cmd_word;
    end
    total++; if (k !== 64) begin bad++; $display("FAIL bp_count got=%0d want=64", k); end
    total++; if (done !== 1'b1 || pass_count !== 16'd1) begin bad++; $display("FAIL bp_end got=%b/%0d want=1/1", done, pass_count); end
    run = 0;
    cmd_ready = 0;
    tick();
  endtask
  task automatic test_config_error();
    for (int t = 0; t < 2; t++) begin
      logic seen = 0;
      start_addr = (t == 1) ? 13'd10 : 13'd50;
      end_addr = (t == 1) ? 13'd20 : 13'd40;
      loop_addr = (t == 1) ? 13'd5 : 13'd0;
      loop_en = t == 1;
      cmd_ready = 1;
      run = 1;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (cmd_valid || busy) seen = 1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL cfg_activity t=%0d got=1 want=0", t); end
      total++; if (done !== 1'b1 || config_error !== 1'b1) begin bad++; $display("FAIL cfg_flags t=%0d got=%b%b want=11", t, done, config_error); end
      run = 0;
      tick();
      total++; if (done !== 1'b0 || config_error !== 1'b0) begin bad++; $display("FAIL cfg_clear t=%0d got=%b%b want=00", t, done, config_error); end
    end
  endtask
  task automatic test_abort_reset();
    int k = 0;
    start_addr = 300;
    end_addr = 304;
    loop_addr = 300;
    loop_en = 1;
    cmd_ready = 1;
    run = 1;
    for (int c = 0; c < 40 && k < 7; c++) begin
      tick();
      if (cmd_valid) begin
        total++; if (cmd_word !== mem[300 + k % 5]) begin bad++; $display("FAIL abort_word k=%0d got=%h want=%h", k, cmd_word, mem[300 + k % 5]); end
        k++;
      end
    end
    run = 0;
    tick();
    total++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b%b want=00", cmd_valid, busy); end
    total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL abort_pass got=%0d want=1", pass_count); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", done); end
    run = 1;
    tick();
    total++; if (RAM_addr_B !== 13'd300 || pass_count !== 16'd0) begin bad++; $display("FAIL rerun_start got=%0d/%0d want=300/0", RAM_addr_B, pass_count); end
    tick();
    tick();
    total++; if (cmd_valid !== 1'b1 || cmd_word !== mem[300]) begin bad++; $display("FAIL rerun_first got=%b/%h want=1/%h", cmd_valid, cmd_word, mem[300]); end
    for (int c = 0; c < 6; c++) tick();
    total++; if (pass_count !== 16'd1) begin bad++; $display("FAIL rerun_pass got=%0d want=1", pass_count); end
    reset_n = 0;
    run = 0;
    tick();
    total++; if ({RAM_addr_B, cmd_word, pass_count} !== 45'd0) begin bad++; $display("FAIL midreset_regs got=%0d/%h/%0d want=0/0/0", RAM_addr_B, cmd_word, pass_count); end
    total++; if ({cmd_valid, busy, done, config_error} !== 4'b0) begin bad++; $display("FAIL midreset_flags got=%b want=0000", {cmd_valid, busy, done, config_error}); end
    reset_n = 1;
    tick();
  endtask
  task automatic test_top_of_memory();
    int k = 0;
    logic low = 0;
    start_addr = 8190;
    end_addr = 8191;
    loop_en = 0;
    cmd_ready = 1;
    run = 1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (busy && RAM_addr_B < 13'd8190) low = 1;
      if (cmd_valid) begin
        if (k < 2) begin
          total++; if (cmd_word !== mem[8190 + k]) begin bad++; $display("FAIL top_word k=%0d got=%h want=%h", k, cmd_word, mem[8190 + k]); end
        end
        k++;
      end
    end
    total++; if (k !== 2) begin bad++; $display("FAIL top_count got=%0d want=2", k); end
    total++; if (low !== 1'b0) begin bad++; $display("FAIL top_wrap got=1 want=0"); end
    total++; if (done !== 1'b1 || pass_count !== 16'd1 || RAM_addr_B !== 13'd8191) begin bad++; $display("FAIL top_end got=%b/%0d/%0d want=1/1/8191", done, pass_count, RAM_addr_B); end
    run = 0;
    tick();
  endtask
  initial begin
    clk = 0;
    reset_n = 0;
    run = 0;
    cmd_ready = 0;
    start_addr = 0;
    end_addr = 0;
    loop_addr = 0;
    loop_en = 0;
    total = 0;
    bad = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'(i * 37) ^ 16'hC35A;
    test_reset();
    test_single_pass();
    test_loop();
    test_backpressure();
    test_config_error();
    test_abort_reset();
    test_top_of_memory();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
